// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, field positions and defaults.
package cp0_exc_ctrl_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int unsigned SR_IE        = 0;
   localparam int unsigned SR_EXL       = 1;
   localparam int unsigned SR_IM_LO     = 10;
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_IP_LO  = 10;
   localparam int unsigned CAUSE_BD     = 31;

   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
   localparam logic [31:0] PRID_DEF         = 32'h4D49_5053;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_HANDLER = 1'b1
   } cp0_state_e;

   // Return address for a faulting instruction: back up over the branch when in a delay slot.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
      return (bd ? pc - 32'd4 : pc) & ~32'h3;
   endfunction

endpackage

// File: rtl/cp0_exc_ctrl_int_arb.sv
// Hardware interrupt masking: any enabled line with its IM bit set raises a request.
module cp0_exc_ctrl_int_arb (
   input  logic [5:0] hwint_i,
   input  logic [5:0] im_i,
   input  logic       ie_i,
   output logic       pend_o
);

   assign pend_o = ie_i & (|(hwint_i & im_i));

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: SR/Cause/EPC/PRId, entry decision and redirect.
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
   parameter logic [31:0] PRID_VAL     = PRID_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        M_valid,
   input  logic [31:0] M_pc,
   input  logic        M_bd,
   input  logic [4:0]  M_exCode,
   input  logic [5:0]  HWInt,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic        eret,
   output logic [31:0] cp0_rdata,
   output logic        exc_req,
   output logic [31:0] exc_pc,
   output logic [31:0] epc_out,
   output logic        in_handler
);

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   cp0_state_e  state_q, state_d;

   logic        int_pend;
   logic        masked;
   logic        int_req;
   logic        exe_req;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   cp0_exc_ctrl_int_arb u_int_arb (
      .hwint_i (HWInt),
      .im_i    (im_q),
      .ie_i    (ie_q),
      .pend_o  (int_pend)
   );

   assign masked  = (state_q == ST_HANDLER);
   assign int_req = int_pend & ~masked & M_valid;
   assign exe_req = (M_exCode != EXC_INT) & ~masked & M_valid;
   // Gated by reset so the redirect is quiet while reset is held, even with a live exCode.
   assign exc_req = (int_req | exe_req) & reset;

   assign exc_pc     = exc_req ? HANDLER_ADDR : epc_q;
   assign epc_out    = epc_q;
   assign in_handler = exl_q;

   always_comb begin
      sr_word                      = '0;
      sr_word[SR_IE]               = ie_q;
      sr_word[SR_EXL]              = exl_q;
      sr_word[SR_IM_LO +: 6]       = im_q;
      cause_word                   = '0;
      cause_word[CAUSE_BD]         = bd_q;
      cause_word[CAUSE_IP_LO +: 6] = ip_q;
      cause_word[CAUSE_EXC_LO +: 5] = exccode_q;
   end

   always_comb begin
      case (cp0_addr)
         CP0_SR:    cp0_rdata = sr_word;
         CP0_CAUSE: cp0_rdata = cause_word;
         CP0_EPC:   cp0_rdata = epc_q;
         CP0_PRID:  cp0_rdata = PRID_VAL;
         default:   cp0_rdata = '0;
      endcase
   end

   always_comb begin
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      ip_d      = HWInt;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      if (exc_req) begin
         exl_d     = 1'b1;
         bd_d      = M_bd;
         exccode_d = int_req ? EXC_INT : M_exCode;
         epc_d     = epc_of(M_pc, M_bd);
      end else begin
         if (cp0_we) begin
            if (cp0_addr == CP0_SR) begin
               im_d  = cp0_wdata[SR_IM_LO +: 6];
               exl_d = cp0_wdata[SR_EXL];
               ie_d  = cp0_wdata[SR_IE];
            end else if (cp0_addr == CP0_EPC) begin
               epc_d = cp0_wdata;
            end
         end
         if (eret) exl_d = 1'b0;
      end
      state_d = exl_d ? ST_HANDLER : ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q      <= '0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= '0;
         exccode_q <= '0;
         epc_q     <= '0;
         state_q   <= ST_IDLE;
      end else begin
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ip_q      <= ip_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
         state_q   <= state_d;
      end
   end

endmodule
